// File: rtl/adc_frame_packer.sv
// adc_frame_packer
// Collects ADC sample sets into two ping-pong banks and streams each full bank
// out as a byte-wide frame: 6-byte header, little-endian payload, XOR checksum.
// The fill side and the emit side work on opposite banks at the same time.
// When a bank is released by the emitter, it can be written again in the same cycle.

module adc_frame_packer #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLE_W  = 10,
    parameter int FRAME_LEN = 256
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
    input  logic                         s_ovr,
    output logic [7:0]                   m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_first,
    output logic                         m_last,
    output logic [15:0]                  drop_cnt,
    output logic                         busy
);

    localparam int BPS = (SAMPLE_W + 7) / 8;
    localparam int DW  = CHANNELS * SAMPLE_W;
    localparam int IW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);
    localparam logic          LAST_BYTE = 1'(BPS - 1);
    localparam logic [15:0]   FL16      = 16'(FRAME_LEN);
    localparam logic [6:0]    CH7       = 7'(CHANNELS);
    localparam logic [DW-1:0] SMASK     = DW'((33'd1 << SAMPLE_W) - 33'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Storage and bank bookkeeping
    // ------------------------------------------------------------------
    logic [DW-1:0] r_mem [2][FRAME_LEN];

    logic          r_fill;
    logic [IW-1:0] r_wr_idx;
    logic [1:0]    r_full;
    logic [1:0]    r_ovr;
    logic          r_ovr_acc;
    logic [15:0]   r_drop;
    logic          r_rd_bank;
    logic [7:0]    r_seq;

    logic          w_rel;
    logic          w_writable;
    logic          w_wr_en;
    logic          w_wr_last;
    logic          w_drop;
    logic          w_xfer;

    // ------------------------------------------------------------------
    // Emit side registers
    // ------------------------------------------------------------------
    state_t        r_state,  w_state_n;
    logic [2:0]    r_hcnt,   w_hcnt_n;
    logic [IW-1:0] r_set,    w_set_n;
    logic [CW-1:0] r_ch,     w_ch_n;
    logic          r_byte,   w_byte_n;
    logic [7:0]    r_csum,   w_csum_n;
    logic [7:0]    r_data,   w_data_n;
    logic          r_valid,  w_valid_n;
    logic          r_first,  w_first_n;
    logic          r_last,   w_last_n;

    // Header byte k of the frame currently owned by the emitter
    function automatic logic [7:0] hdr_byte(input logic [2:0] k,
                                            input logic       ovr,
                                            input logic [7:0] seq);
        logic [7:0] b;
        case (k)
            3'd0:    b = 8'hA5;
            3'd1:    b = 8'h5A;
            3'd2:    b = {ovr, CH7};
            3'd3:    b = seq;
            3'd4:    b = FL16[15:8];
            default: b = FL16[7:0];
        endcase
        return b;
    endfunction

    // One byte of one channel, zero-extended and little-endian
    function automatic logic [7:0] pay_byte(input logic [DW-1:0] word,
                                            input logic [CW-1:0] ch,
                                            input logic          b);
        logic [15:0] smp;
        smp = 16'((word >> (SAMPLE_W * ch)) & SMASK);
        return b ? smp[15:8] : smp[7:0];
    endfunction

    // A bank released by the emitter this cycle counts as empty for the writer
    assign w_writable = !r_full[r_fill] || (w_rel && (r_rd_bank == r_fill));
    assign w_wr_en    = s_valid && w_writable;
    assign w_drop     = s_valid && !w_writable;
    assign w_wr_last  = w_wr_en && (r_wr_idx == LAST_IDX);
    assign w_xfer     = r_valid && m_ready;

    // Sample storage; contents are don't-care until a bank is marked full
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_fill][r_wr_idx] <= s_data;
        end
    end

    // Fill pointer, bank full/ovr flags, release, sequence and drop counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fill    <= 1'b0;
            r_wr_idx  <= '0;
            r_full    <= 2'b00;
            r_ovr     <= 2'b00;
            r_ovr_acc <= 1'b0;
            r_drop    <= 16'd0;
            r_rd_bank <= 1'b0;
            r_seq     <= 8'd0;
        end else begin
            if (w_rel) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
                r_seq             <= r_seq + 8'd1;
            end
            if (w_wr_en) begin
                if (w_wr_last) begin
                    // set after the release clear so a reused bank ends up full
                    r_full[r_fill] <= 1'b1;
                    r_ovr[r_fill]  <= r_ovr_acc | s_ovr;
                    r_ovr_acc      <= 1'b0;
                    r_fill         <= ~r_fill;
                    r_wr_idx       <= '0;
                end else begin
                    r_wr_idx  <= r_wr_idx + IW'(1);
                    r_ovr_acc <= r_ovr_acc | s_ovr;
                end
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    // Emit FSM state and output byte registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_hcnt  <= 3'd0;
            r_set   <= '0;
            r_ch    <= '0;
            r_byte  <= 1'b0;
            r_csum  <= 8'd0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_hcnt  <= w_hcnt_n;
            r_set   <= w_set_n;
            r_ch    <= w_ch_n;
            r_byte  <= w_byte_n;
            r_csum  <= w_csum_n;
            r_data  <= w_data_n;
            r_valid <= w_valid_n;
            r_first <= w_first_n;
            r_last  <= w_last_n;
        end
    end

    // Next byte selection: the output register holds the byte on offer, and the
    // following byte is loaded on the transfer edge so there are no bubbles.
    // r_csum is the XOR of every byte loaded so far in this frame.
    always_comb begin
        w_state_n = r_state;
        w_hcnt_n  = r_hcnt;
        w_set_n   = r_set;
        w_ch_n    = r_ch;
        w_byte_n  = r_byte;
        w_csum_n  = r_csum;
        w_data_n  = r_data;
        w_valid_n = r_valid;
        w_first_n = r_first;
        w_last_n  = r_last;
        w_rel     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // the oldest full bank is always the one the emitter points at
                if (r_full[r_rd_bank]) begin
                    w_state_n = S_HDR;
                    w_hcnt_n  = 3'd0;
                    w_data_n  = 8'hA5;
                    w_csum_n  = 8'hA5;
                    w_valid_n = 1'b1;
                    w_first_n = 1'b1;
                    w_last_n  = 1'b0;
                end
            end

            S_HDR: begin
                if (w_xfer) begin
                    w_first_n = 1'b0;
                    if (r_hcnt == 3'd5) begin
                        w_state_n = S_PAY;
                        w_set_n   = '0;
                        w_ch_n    = '0;
                        w_byte_n  = 1'b0;
                        w_data_n  = pay_byte(r_mem[r_rd_bank][IW'(0)], CW'(0), 1'b0);
                    end else begin
                        w_hcnt_n = r_hcnt + 3'd1;
                        w_data_n = hdr_byte(w_hcnt_n, r_ovr[r_rd_bank], r_seq);
                    end
                    w_csum_n = r_csum ^ w_data_n;
                end
            end

            S_PAY: begin
                if (w_xfer) begin
                    if ((r_byte == LAST_BYTE) && (r_ch == LAST_CH) && (r_set == LAST_IDX)) begin
                        w_state_n = S_CSUM;
                        w_data_n  = r_csum;
                        w_last_n  = 1'b1;
                    end else begin
                        if (r_byte != LAST_BYTE) begin
                            w_byte_n = r_byte + 1'b1;
                        end else begin
                            w_byte_n = 1'b0;
                            if (r_ch != LAST_CH) begin
                                w_ch_n = r_ch + CW'(1);
                            end else begin
                                w_ch_n  = '0;
                                w_set_n = r_set + IW'(1);
                            end
                        end
                        w_data_n = pay_byte(r_mem[r_rd_bank][w_set_n], w_ch_n, w_byte_n);
                        w_csum_n = r_csum ^ w_data_n;
                    end
                end
            end

            S_CSUM: begin
                if (w_xfer) begin
                    w_rel    = 1'b1;
                    w_last_n = 1'b0;
                    // chain straight into the other bank's frame if it is waiting
                    if (r_full[~r_rd_bank]) begin
                        w_state_n = S_HDR;
                        w_hcnt_n  = 3'd0;
                        w_data_n  = 8'hA5;
                        w_csum_n  = 8'hA5;
                        w_valid_n = 1'b1;
                        w_first_n = 1'b1;
                    end else begin
                        w_state_n = S_IDLE;
                        w_data_n  = 8'd0;
                        w_valid_n = 1'b0;
                        w_first_n = 1'b0;
                    end
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_valid_n = 1'b0;
            end
        endcase
    end

    assign m_data   = r_data;
    assign m_valid  = r_valid;
    assign m_first  = r_first;
    assign m_last   = r_last;
    assign drop_cnt = r_drop;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer with CHANNELS=2, SAMPLE_W=10, FRAME_LEN=4.
// A 23-byte frame is expected for every full bank.

module tb_adc_frame_packer;

    localparam int CH   = 2;
    localparam int SW   = 10;
    localparam int FL   = 4;
    localparam int FLEN = 23;

    typedef logic [9:0] set4_t [4];
    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
        int         cyc;
    } xfer_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             s_valid = 1'b0;
    logic [CH*SW-1:0] s_data = '0;
    logic             s_ovr = 1'b0;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_first;
    logic             m_last;
    logic [15:0]      drop_cnt;
    logic             busy;

    int    n_checks = 0;
    int    n_errors = 0;
    xfer_t q[$];
    int    n_xfer = 0;
    int    cyc = 0;
    logic  rdy_rand = 1'b0;
    logic  rdy_val = 1'b0;
    logic  prev_stall = 1'b0;
    logic [9:0] prev_out = '0;
    int    fr_first_cyc = 0;
    int    fr_last_cyc = 0;

    logic [7:0] s1_exp [FLEN];
    set4_t a0, a1, b0, b1, d0, d1;

    adc_frame_packer #(
        .CHANNELS (CH),
        .SAMPLE_W (SW),
        .FRAME_LEN(FL)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ovr   (s_ovr),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_first (m_first),
        .m_last  (m_last),
        .drop_cnt(drop_cnt),
        .busy    (busy)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // m_ready driver: fixed level or coin flip per cycle
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Byte collector and stall-hold check, away from the active edge
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                assert ({m_valid, m_data, m_first, m_last} === {1'b1, prev_out})
                else begin
                    n_errors++;
                    $error("FAIL stall_hold observed=%h expected=%h",
                           {m_valid, m_data, m_first, m_last}, {1'b1, prev_out});
                end
            end
            if (m_valid && m_ready) begin
                q.push_back('{d: m_data, f: m_first, l: m_last, cyc: cyc});
                n_xfer++;
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_data, m_first, m_last};
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [9:0] c0, input logic [9:0] c1, input logic ov);
        s_valid = 1'b1;
        s_data  = {c1, c0};
        s_ovr   = ov;
        idle(1);
        s_valid = 1'b0;
        s_data  = '0;
        s_ovr   = 1'b0;
    endtask

    task automatic send4(input set4_t c0, input set4_t c1, input int ovr_idx);
        for (int i = 0; i < 4; i++) send(c0[i], c1[i], 1'(i == ovr_idx));
    endtask

    task automatic wait_n(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_xfer < target && k < budget) begin
            idle(1);
            k++;
        end
        chk(tag, 32'(n_xfer >= target), 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        q.delete();
        n_xfer = 0;
        idle(1);
    endtask

    // Expected frame built from the documented byte layout
    task automatic check_frame(input string tag, input logic ov, input logic [7:0] sq,
                               input set4_t c0, input set4_t c1);
        logic [7:0] exp [FLEN];
        logic [7:0] x;
        xfer_t      t;
        exp[0] = 8'hA5;
        exp[1] = 8'h5A;
        exp[2] = {ov, 7'd2};
        exp[3] = sq;
        exp[4] = 8'h00;
        exp[5] = 8'h04;
        for (int s = 0; s < 4; s++) begin
            exp[6 + 4*s] = c0[s][7:0];
            exp[7 + 4*s] = {6'b0, c0[s][9:8]};
            exp[8 + 4*s] = c1[s][7:0];
            exp[9 + 4*s] = {6'b0, c1[s][9:8]};
        end
        x = 8'h00;
        for (int i = 0; i < FLEN - 1; i++) x = x ^ exp[i];
        exp[FLEN-1] = x;
        if (q.size() < FLEN) begin
            chk({tag, "_count"}, 32'(q.size()), 32'(FLEN));
        end else begin
            for (int i = 0; i < FLEN; i++) begin
                t = q.pop_front();
                if (i == 0) fr_first_cyc = t.cyc;
                if (i == FLEN - 1) fr_last_cyc = t.cyc;
                chk($sformatf("%s_b%0d", tag, i), {22'd0, t.d, t.f, t.l},
                    {22'd0, exp[i], 1'(i == 0), 1'(i == FLEN - 1)});
            end
        end
    endtask

    initial begin
        int   last_cyc;
        xfer_t t;

        s1_exp = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h00, 8'h04,
                   8'h01, 8'h00, 8'hFF, 8'h03, 8'h01, 8'h00, 8'hFF, 8'h03,
                   8'h01, 8'h00, 8'hFF, 8'h03, 8'h01, 8'h00, 8'hFF, 8'h03,
                   8'hF9};
        a0 = '{10'h100, 10'h101, 10'h102, 10'h103};
        a1 = '{10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC};
        b0 = '{10'h0F0, 10'h2A5, 10'h15A, 10'h000};
        b1 = '{10'h001, 10'h080, 10'h37F, 10'h2C3};
        d0 = '{10'h155, 10'h0AB, 10'h3C3, 10'h001};
        d1 = '{10'h2AA, 10'h300, 10'h03C, 10'h1FE};

        // ---- reset state ----
        idle(2);
        rstn = 1'b1;
        idle(1);
        chk("reset_outputs", {8'd0, m_data, m_valid, m_first, m_last, busy, 12'd0},
            32'd0);
        chk("reset_drop", {16'd0, drop_cnt}, 32'd0);

        // ---- 1 basic frame ----
        rdy_val = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) send(10'h001, 10'h3FF, 1'b0);
        wait_n(FLEN, 100, "s1_wait");
        for (int i = 0; i < FLEN; i++) begin
            if (q.size() > 0) begin
                t = q.pop_front();
                chk($sformatf("s1_b%0d", i), {22'd0, t.d, t.f, t.l},
                    {22'd0, s1_exp[i], 1'(i == 0), 1'(i == FLEN - 1)});
            end
        end
        idle(5);
        chk("s1_busy_after", {31'd0, busy}, 32'd0);
        chk("s1_no_extra", 32'(q.size()), 32'd0);

        // ---- 2 backpressure ----
        do_reset();
        rdy_rand = 1'b1;
        for (int i = 0; i < 4; i++) send(10'h001, 10'h3FF, 1'b0);
        wait_n(FLEN, 400, "s2_wait");
        for (int i = 0; i < FLEN; i++) begin
            if (q.size() > 0) begin
                t = q.pop_front();
                chk($sformatf("s2_b%0d", i), {22'd0, t.d, t.f, t.l},
                    {22'd0, s1_exp[i], 1'(i == 0), 1'(i == FLEN - 1)});
            end
        end
        idle(20);
        chk("s2_no_extra", 32'(q.size()), 32'd0);
        rdy_rand = 1'b0;

        // ---- 3 overrun, plus first-byte latency ----
        do_reset();
        rdy_val = 1'b0;
        idle(2);
        send4(a0, a1, -1);
        idle(2);
        chk("s3_latency", {22'd0, m_valid, m_first, m_data}, {22'd0, 1'b1, 1'b1, 8'hA5});
        chk("s3_busy", {31'd0, busy}, 32'd1);
        send4(b0, b1, -1);
        for (int i = 0; i < 4; i++) send(10'h0AA, 10'h155, 1'b0);
        chk("s3_drop_cnt", {16'd0, drop_cnt}, 32'd4);
        chk("s3_nothing_sent", 32'(n_xfer), 32'd0);
        rdy_val = 1'b1;
        wait_n(2*FLEN, 200, "s3_wait");
        check_frame("s3f0", 1'b0, 8'h00, a0, a1);
        last_cyc = fr_last_cyc;
        check_frame("s3f1", 1'b0, 8'h01, b0, b1);
        chk("s3_gap", 32'(fr_first_cyc), 32'(last_cyc + 1));
        idle(30);
        chk("s3_no_extra", 32'(q.size()), 32'd0);

        // ---- 4 over-range ----
        do_reset();
        rdy_val = 1'b1;
        idle(2);
        send4(b0, b1, 2);
        send4(a0, a1, -1);
        wait_n(2*FLEN, 200, "s4_wait");
        check_frame("s4f0", 1'b1, 8'h00, b0, b1);
        check_frame("s4f1", 1'b0, 8'h01, a0, a1);

        // ---- 5 sequence wrap, back-to-back frames ----
        do_reset();
        rdy_val = 1'b1;
        idle(2);
        send4(d0, d1, -1);
        send4(d0, d1, -1);
        for (int k = 0; k < 255; k++) begin
            wait_n(FLEN*(k+1), 100, "s5_pace");
            idle(3);
            send4(d0, d1, -1);
        end
        wait_n(FLEN*257, 200, "s5_wait");
        chk("s5_drop", {16'd0, drop_cnt}, 32'd0);
        for (int f = 0; f < 257; f++) begin
            check_frame($sformatf("s5f%0d", f), 1'b0, 8'(f), d0, d1);
            if (f > 0) chk($sformatf("s5_gap%0d", f), 32'(fr_first_cyc), 32'(last_cyc + 1));
            last_cyc = fr_last_cyc;
        end

        // ---- 6 reset mid-frame ----
        do_reset();
        rdy_val = 1'b1;
        idle(2);
        send4(a0, a1, -1);
        send4(b0, b1, -1);
        for (int i = 0; i < 4; i++) send(10'h0AA, 10'h155, 1'b0);
        wait_n(10, 100, "s6_wait_pay");
        chk("s6_drop_before", {16'd0, drop_cnt}, 32'd4);
        chk("s6_busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("s6_outputs_in_reset", {8'd0, m_data, m_valid, m_first, m_last, busy, 12'd0},
            32'd0);
        chk("s6_drop_in_reset", {16'd0, drop_cnt}, 32'd0);
        idle(2);
        rstn = 1'b1;
        q.delete();
        n_xfer = 0;
        idle(1);
        send4(d0, d1, -1);
        wait_n(FLEN, 100, "s6_wait");
        check_frame("s6f0", 1'b0, 8'h00, d0, d1);
        idle(40);
        chk("s6_no_ghost", 32'(n_xfer), 32'(FLEN));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
